pia_bus_responder: RTL and testbench

CPU-facing peripheral responder for the 6502 bus. It decodes four registers at `BASE..BASE+3` and answers reads and writes qualified by the CPU clock enable. It implements the keyboard-input and display-output ports: a one-entry keyboard holding register with a strobe, and a display FIFO with a valid/ready drain. It sits beside the CPU core; its `dout`/`dout_valid` feed the top-level read-data mux.

---
 rtl/pia_bus_if.sv | 28 ++
 rtl/pia_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_pia_bus_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pia_bus_if.sv
// pia_bus_if: 6502-side bus bundle between the CPU core and the PIA responder.
//   enable     CPU cycle strobe. The remaining request fields are valid only while it is 1.
//   ab         CPU address.
//   din        CPU write data.
//   we         1 = write, 0 = read.
//   dout       Registered read data returned by the responder.
//   dout_valid Registered flag: the last enabled access was a read that hit the responder.
//   irq_n      Active-low keyboard interrupt.
// Modports: master is the CPU side, slave is the responder side.
interface pia_bus_if;
  logic        enable;
  logic [15:0] ab;
  logic [7:0]  din;
  logic        we;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        irq_n;

  modport master (
    output enable, ab, din, we,
    input  dout, dout_valid, irq_n
  );

  modport slave (
    input  enable, ab, din, we,
    output dout, dout_valid, irq_n
  );
endinterface

// File: rtl/pia_bus_responder.sv
// pia_bus_responder: CPU-facing keyboard/display responder on the 6502 bus.
// Four registers are decoded at BASE..BASE+3:
//   +0 KBD    read {1, key}. The read clears strobe. Writes are ignored.
//   +1 KBDCR  read {strobe, kcr}. A write loads kcr.
//   +2 DSP    read {full, last}. A write pushes a character into the display FIFO and updates last.
//   +3 DSPCR  read {ovf, dcr}. A write loads dcr and clears ovf.
// Ports:
//   clk, reset                  Clock and asynchronous active-high reset.
//   bus (pia_bus_if.slave)      CPU request fields, plus registered read data, read-valid and irq_n.
//   kbd_data/kbd_valid/kbd_ready  Keyboard source handshake. There is one holding register.
//   dsp_data/dsp_valid/dsp_ready  Display sink handshake. It drains the head of the FIFO.
module pia_bus_responder #(
  parameter logic [15:0] BASE      = 16'hD010,
  parameter int          DSP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  pia_bus_if.slave   bus,
  input  logic [6:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  output logic [6:0] dsp_data,
  output logic       dsp_valid,
  input  logic       dsp_ready
);

  localparam int AW = $clog2(DSP_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    REG_KBD   = 2'd0,
    REG_KBDCR = 2'd1,
    REG_DSP   = 2'd2,
    REG_DSPCR = 2'd3
  } reg_sel_e;

  // Register state
  logic [6:0] key;
  logic       strobe;
  logic [6:0] kcr;
  logic [6:0] dcr;
  logic [6:0] last;
  logic       ovf;

  // Display FIFO
  logic [6:0]    fifo_mem [DSP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Decode
  logic     hit;
  logic     rd_acc;
  logic     wr_acc;
  reg_sel_e sel;
  logic     full;
  logic     empty;
  logic     push_req;
  logic     push;
  logic     pop;
  logic     kbd_fire;
  logic     kbd_clear;
  logic [7:0] rd_data;

  assign hit      = bus.enable && (bus.ab[15:2] == BASE[15:2]);
  assign rd_acc   = hit && !bus.we;
  assign wr_acc   = hit && bus.we;
  assign sel      = reg_sel_e'(bus.ab[1:0]);

  assign full     = (count == CW'(DSP_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_acc && (sel == REG_DSP);
  // Full is judged on the pre-edge count. A push into a full FIFO is
  // dropped even if the sink pops on the same edge.
  assign push     = push_req && !full;
  assign pop      = !empty && dsp_ready;

  assign kbd_ready = !strobe;
  // kbd_ready is the inverse of strobe, so a handshake only fires while strobe is clear.
  assign kbd_fire  = kbd_valid && !strobe;
  assign kbd_clear = rd_acc && (sel == REG_KBD);

  assign dsp_data  = fifo_mem[rd_ptr];
  assign dsp_valid = !empty;
  assign bus.irq_n = !(strobe && kcr[0]);

  // Read mux. It uses pre-edge state, so a clearing KBD read still returns
  // the old key and a KBDCR read sees the old strobe.
  always_comb begin
    // NOTE: default first, so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    unique case (sel)
      REG_KBD:   rd_data = {1'b1, key};
      REG_KBDCR: rd_data = {strobe, kcr};
      REG_DSP:   rd_data = {full, last};
      REG_DSPCR: rd_data = {ovf, dcr};
    endcase
  end

  // NOTE: state is updated with non-blocking assignments. Every term on the
  // right-hand side therefore reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      key            <= '0;
      strobe         <= 1'b0;
      kcr            <= '0;
      dcr            <= '0;
      last           <= '0;
      ovf            <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      if (bus.enable) begin
        bus.dout_valid <= rd_acc;
        bus.dout       <= rd_acc ? rd_data : 8'h00;
      end

      if (wr_acc) begin
        unique case (sel)
          REG_KBD:   ;
          REG_KBDCR: kcr <= bus.din[6:0];
          REG_DSP: begin
            last <= bus.din[6:0];
            if (full) ovf <= 1'b1;
          end
          REG_DSPCR: begin
            dcr <= bus.din[6:0];
            ovf <= 1'b0;
          end
        endcase
      end

      // A new key takes priority over a clearing read on the same edge,
      // so that key is not lost.
      if (kbd_fire) begin
        key    <= kbd_data;
        strobe <= 1'b1;
      end else if (kbd_clear) begin
        strobe <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset. The count gates visibility, and
  // stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.din[6:0];
  end

endmodule

// File: tb/tb_pia_bus_responder.sv
// Self-checking bench for pia_bus_responder.
// A behavioural model keeps the register values as plain variables and the
// display FIFO as a queue. After every edge the outputs are compared against
// the model. Directed phases add literal expectations, and a randomized phase follows them.
module tb_pia_bus_responder;

  localparam logic [15:0] BASE  = 16'hD010;
  localparam int          DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic [6:0] dsp_data;
  logic       dsp_valid;
  logic       dsp_ready;

  pia_bus_if bus ();

  pia_bus_responder #(.BASE(BASE), .DSP_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [6:0] m_key, m_kcr, m_dcr, m_last;
  bit         m_strobe, m_ovf, m_dv;
  logic [7:0] m_dout;
  logic [6:0] m_fifo[$];
  logic [6:0] rx[$];   // characters the sink actually took from the DUT

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_kcr = '0; m_dcr = '0; m_last = '0;
    m_strobe = 0; m_ovf = 0; m_dv = 0; m_dout = '0;
    m_fifo.delete();
  endtask

  // One edge of the behavioural model. It reads the inputs that are stable
  // across the edge, and the results are computed from pre-edge model state.
  task automatic model_step();
    bit         hit, pushing, popping, was_full;
    int         reg_idx;
    if (reset) begin
      model_reset();
      return;
    end
    hit      = bus.enable && (bus.ab >= BASE) && (bus.ab <= BASE + 16'd3);
    reg_idx  = int'(bus.ab) - int'(BASE);
    was_full = (m_fifo.size() == DEPTH);
    popping  = (m_fifo.size() > 0) && dsp_ready;
    pushing  = 0;
    if (bus.enable) begin
      m_dv   = hit && !bus.we;
      m_dout = 8'h00;
      if (hit && !bus.we) begin
        case (reg_idx)
          0: m_dout = {1'b1, m_key};
          1: m_dout = {m_strobe, m_kcr};
          2: m_dout = {was_full, m_last};
          default: m_dout = {m_ovf, m_dcr};
        endcase
      end
    end
    if (hit && bus.we) begin
      case (reg_idx)
        1: m_kcr = bus.din[6:0];
        2: begin
          m_last = bus.din[6:0];
          if (was_full) m_ovf = 1;
          else pushing = 1;
        end
        3: begin m_dcr = bus.din[6:0]; m_ovf = 0; end
        default: ;
      endcase
    end
    if (kbd_valid && !m_strobe) begin
      m_key = kbd_data;
      m_strobe = 1;
    end else if (hit && !bus.we && reg_idx == 0) begin
      m_strobe = 0;
    end
    if (popping) void'(m_fifo.pop_front());
    if (pushing) m_fifo.push_back(bus.din[6:0]);
  endtask

  task automatic compare();
    check("dout", bus.dout, m_dout);
    check("dout_valid", bus.dout_valid, m_dv);
    check("irq_n", bus.irq_n, !(m_strobe && m_kcr[0]));
    check("kbd_ready", kbd_ready, !m_strobe);
    check("dsp_valid", dsp_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) check("dsp_data", dsp_data, m_fifo[0]);
  endtask

  // Called at a falling edge with inputs already set. It advances one clock
  // and returns at the next falling edge, after the outputs are compared.
  task automatic tick();
    if (!reset && dsp_valid && dsp_ready) rx.push_back(dsp_data);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus.enable = 1; bus.ab = a; bus.we = w; bus.din = d;
    tick();
    bus.enable = 0; bus.we = 0;
  endtask

  task automatic offer_key(input logic [6:0] k);
    kbd_valid = 1; kbd_data = k;
    tick();
    kbd_valid = 0;
  endtask

  task automatic drain(input int budget);
    dsp_ready = 1;
    for (int i = 0; i < budget && dsp_valid; i++) tick();
    dsp_ready = 0;
    check("drain_done", dsp_valid, 1'b0);
  endtask

  initial begin
    reset = 1; bus.enable = 0; bus.ab = '0; bus.we = 0; bus.din = '0;
    kbd_data = '0; kbd_valid = 0; dsp_ready = 0;
    model_reset();
    tick();
    tick();
    reset = 0;
    tick();
    check("rst_dout", bus.dout, 8'h00);
    check("rst_dv", bus.dout_valid, 1'b0);
    check("rst_irq_n", bus.irq_n, 1'b1);
    check("rst_kbd_ready", kbd_ready, 1'b1);
    check("rst_dsp_valid", dsp_valid, 1'b0);

    // Keyboard path
    offer_key(7'h41);
    check("key_ready_low", kbd_ready, 1'b0);
    access(16'hD011, 0, 0);
    check("kbdcr_strobe", bus.dout, 8'h80);
    access(16'hD010, 0, 0);
    check("kbd_read", bus.dout, 8'hC1);
    check("kbd_read_dv", bus.dout_valid, 1'b1);
    check("kbd_ready_after_clear", kbd_ready, 1'b1);
    access(16'hD011, 0, 0);
    check("kbdcr_cleared", bus.dout, 8'h00);

    // Interrupt
    access(16'hD011, 1, 8'h01);
    offer_key(7'h42);
    check("irq_asserted", bus.irq_n, 1'b0);
    access(16'hD010, 0, 0);
    check("kbd_read2", bus.dout, 8'hC2);
    check("irq_released", bus.irq_n, 1'b1);

    // FIFO fill and overflow
    dsp_ready = 0;
    for (int i = 0; i < 4; i++) access(16'hD012, 1, 8'h31 + 8'(i));
    access(16'hD012, 0, 0);
    check("dsp_full_read", bus.dout, 8'hB4);
    access(16'hD012, 1, 8'h35);
    access(16'hD013, 0, 0);
    check("ovf_set", bus.dout, 8'h80);
    rx.delete();
    drain(16);
    check("drain_count", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) check("drain_order", rx[i], 7'h31 + 7'(i));
    access(16'hD013, 1, 8'h00);
    access(16'hD013, 0, 0);
    check("ovf_cleared", bus.dout, 8'h00);

    // Streaming: one push per cycle with the sink always ready
    rx.delete();
    dsp_ready = 1;
    for (int i = 0; i < 8; i++) access(16'hD012, 1, 8'h50 + 8'(i));
    drain(16);
    check("stream_count", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++) check("stream_order", rx[i], 7'h50 + 7'(i));
    access(16'hD013, 0, 0);
    check("stream_no_ovf", bus.dout, 8'h00);

    // Full FIFO: push and pop on the same edge
    dsp_ready = 0;
    for (int i = 0; i < 4; i++) access(16'hD012, 1, 8'h61 + 8'(i));
    rx.delete();
    dsp_ready = 1;
    access(16'hD012, 1, 8'h65);
    dsp_ready = 0;
    check("full_pushpop_pop", rx.size(), 1);
    access(16'hD013, 0, 0);
    check("full_pushpop_ovf", bus.dout, 8'h80);
    drain(16);
    check("full_pushpop_total", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) check("full_pushpop_order", rx[i], 7'h61 + 7'(i));

    // Decode boundary
    access(16'hD013, 1, 8'h15);
    access(16'hD00F, 0, 0);
    check("d00f_dv", bus.dout_valid, 1'b0);
    check("d00f_dout", bus.dout, 8'h00);
    access(16'hD014, 1, 8'h7F);
    access(16'hD014, 0, 0);
    check("d014_dv", bus.dout_valid, 1'b0);
    check("d014_dout", bus.dout, 8'h00);
    access(16'hD00F, 1, 8'h22);
    access(16'hD013, 0, 0);
    check("dcr_untouched", bus.dout, 8'h15);

    // Randomized traffic around and inside the register window
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1;
        tick();
        reset = 0;
      end
      bus.enable = ($urandom_range(0, 1) == 1);
      bus.ab     = 16'hD00E + 16'($urandom_range(0, 7));
      bus.we     = ($urandom_range(0, 1) == 1);
      bus.din    = 8'($urandom);
      kbd_valid  = ($urandom_range(0, 3) == 0);
      kbd_data   = 7'($urandom);
      dsp_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
